// File: rtl/booth_sequencer.sv
// booth_sequencer: control FSM for a radix-2 Booth multiplier datapath.
// Sequences init, width evaluate/shift iterations, and a done pulse.
module booth_sequencer #(
  parameter  int width = 16,
  localparam int CW    = $clog2(width)
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          Begin,
  input  logic          Abort,
  input  logic          mLSB,
  input  logic          Q_neg,
  output logic          Init,
  output logic          LoadA,
  output logic          AddSub,
  output logic          Shift,
  output logic          Busy,
  output logic          End,
  output logic [CW-1:0] Iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_iter;
  logic [1:0]    w_pair;
  logic          w_last;

  assign w_pair = {mLSB, Q_neg};
  assign w_last = (r_iter == LAST);
  assign Iter   = r_iter;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT)
        r_iter <= '0;
      else if (r_state == S_SHIFT && !w_last && !Abort)
        r_iter <= r_iter + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    Init   = 1'b0;
    LoadA  = 1'b0;
    AddSub = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    End    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Begin)
          w_next = S_INIT;
      end
      S_INIT: begin
        Init   = 1'b1;
        Busy   = 1'b1;
        w_next = S_EVAL;
      end
      S_EVAL: begin
        Busy   = 1'b1;
        w_next = S_SHIFT;
        // Booth pair {Q0, Q-1}: 10 subtracts, 01 adds
        case (w_pair)
          2'b10: begin
            LoadA  = 1'b1;
            AddSub = 1'b1;
          end
          2'b01: LoadA = 1'b1;
          default: ;
        endcase
      end
      S_SHIFT: begin
        Shift  = 1'b1;
        Busy   = 1'b1;
        w_next = w_last ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        End    = 1'b1;
        Busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort wins over everything, and in IDLE it swallows Begin
    if (Abort)
      w_next = S_IDLE;
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: randomized self-checking bench for booth_sequencer.
// Cycle-indexed reference model plus a behavioural Booth datapath.
module tb_booth_sequencer;

  localparam int W   = 16;
  localparam int CW  = $clog2(W);
  localparam int RUN = 2 * W + 2;

  logic          CLK    = 1'b0;
  logic          R      = 1'b1;
  logic          Begin  = 1'b0;
  logic          Abort  = 1'b0;
  logic          drv_m  = 1'b0;
  logic          drv_q  = 1'b0;
  logic          use_dp = 1'b0;
  logic          mLSB;
  logic          Q_neg;
  logic          Init;
  logic          LoadA;
  logic          AddSub;
  logic          Shift;
  logic          Busy;
  logic          End;
  logic [CW-1:0] Iter;
  logic [5:0]    obs;

  logic [W:0]    dp_a;
  logic [W-1:0]  dp_q;
  logic          dp_qm1;
  logic [W-1:0]  dp_mcand  = '0;
  logic [W-1:0]  dp_mplier = '0;

  int n_cmp = 0;
  int n_err = 0;

  booth_sequencer #(.width(W)) dut (
    .CLK    (CLK),
    .R      (R),
    .Begin  (Begin),
    .Abort  (Abort),
    .mLSB   (mLSB),
    .Q_neg  (Q_neg),
    .Init   (Init),
    .LoadA  (LoadA),
    .AddSub (AddSub),
    .Shift  (Shift),
    .Busy   (Busy),
    .End    (End),
    .Iter   (Iter)
  );

  always #5 CLK = ~CLK;

  assign obs   = {Init, LoadA, AddSub, Shift, Busy, End};
  assign mLSB  = use_dp ? dp_q[0] : drv_m;
  assign Q_neg = use_dp ? dp_qm1  : drv_q;

  // Extended accumulator keeps the most negative multiplicand exact
  always_ff @(posedge CLK) begin
    if (Init) begin
      dp_a   <= '0;
      dp_q   <= dp_mplier;
      dp_qm1 <= 1'b0;
    end else if (LoadA) begin
      if (AddSub)
        dp_a <= dp_a - {dp_mcand[W-1], dp_mcand};
      else
        dp_a <= dp_a + {dp_mcand[W-1], dp_mcand};
    end else if (Shift) begin
      {dp_a, dp_q, dp_qm1} <= {dp_a[W], dp_a, dp_q};
    end
  end

  // Expected {Init,LoadA,AddSub,Shift,Busy,End} in cycle c after Begin
  function automatic logic [5:0] exp_ctl(int c, logic m, logic qn);
    logic [5:0] e;
    e = 6'b0;
    if (c == 1)
      e = 6'b100010;
    else if (c >= 2 && c <= 2 * W + 1) begin
      if (c % 2 == 0) begin
        e[4] = m ^ qn;
        e[3] = m & ~qn;
        e[1] = 1'b1;
      end else
        e = 6'b000110;
    end else if (c == RUN)
      e = 6'b000011;
    return e;
  endfunction

  function automatic int exp_iter(int c);
    if (c >= RUN)
      return W - 1;
    return (c - 2) / 2;
  endfunction

  task automatic test_reset();
    #1 R = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 6'b0 || Iter !== '0) begin
      n_err++;
      $display("FAIL reset_init got=%b/%0d exp=000000/0", obs, Iter);
    end
    @(negedge CLK);
    R = 1'b1;
    drv_m = 1'b1;
    drv_q = 1'b0;
    @(negedge CLK);
    Begin = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      Begin = 1'b0;
    end
    n_cmp++;
    if (obs !== 6'b011010) begin
      n_err++;
      $display("FAIL reset_pre_eval got=%b exp=011010", obs);
    end
    #2 R = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 6'b0 || Iter !== '0) begin
      n_err++;
      $display("FAIL reset_async got=%b/%0d exp=000000/0", obs, Iter);
    end
    @(negedge CLK);
    R = 1'b1;
    drv_m = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (obs !== 6'b0 || Iter !== '0) begin
      n_err++;
      $display("FAIL reset_release got=%b/%0d exp=000000/0", obs, Iter);
    end
  endtask

  task automatic test_basic();
    int   n_sh;
    int   n_end;
    int   n_ld;
    logic [5:0] e;
    n_sh  = 0;
    n_end = 0;
    n_ld  = 0;
    drv_m = 1'b0;
    drv_q = 1'b0;
    @(negedge CLK);
    Begin = 1'b1;
    for (int c = 1; c <= RUN + 2; c++) begin
      @(negedge CLK);
      Begin = 1'b0;
      e = exp_ctl(c, 1'b0, 1'b0);
      n_sh  += int'(Shift);
      n_end += int'(End);
      n_ld  += int'(LoadA);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL basic_ctl c=%0d got=%b exp=%b", c, obs, e);
      end
      if (c >= 2 && c <= RUN) begin
        n_cmp++;
        if (int'(Iter) != exp_iter(c)) begin
          n_err++;
          $display("FAIL basic_iter c=%0d got=%0d exp=%0d",
                   c, Iter, exp_iter(c));
        end
      end
    end
    n_cmp++;
    if (n_sh != W || n_end != 1 || n_ld != 0) begin
      n_err++;
      $display("FAIL basic_counts got=%0d/%0d/%0d exp=%0d/1/0",
               n_sh, n_end, n_ld, W);
    end
  endtask

  task automatic test_decode();
    logic [1:0] pat [4];
    logic [1:0] p;
    logic [5:0] e;
    int         k;
    pat[0] = 2'b10;
    pat[1] = 2'b01;
    pat[2] = 2'b11;
    pat[3] = 2'b00;
    @(negedge CLK);
    Begin = 1'b1;
    for (int c = 1; c <= RUN + 1; c++) begin
      @(negedge CLK);
      Begin = 1'b0;
      e = exp_ctl(c, drv_m, drv_q);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL decode c=%0d pair=%b%b got=%b exp=%b",
                 c, drv_m, drv_q, obs, e);
      end
      k = (c - 1) / 2;
      p = (k < 4) ? pat[k] : 2'($urandom);
      {drv_m, drv_q} = p;
    end
    drv_m = 1'b0;
    drv_q = 1'b0;
  endtask

  task automatic test_datapath();
    logic [W-1:0]   mc [8];
    logic [W-1:0]   mp [8];
    logic [2*W-1:0] prod;
    logic [5:0]     e;
    longint         ref_p;
    mc[0] = 16'h0007;
    mp[0] = 16'hFFFD;
    mc[1] = 16'h8000;
    mp[1] = 16'h8000;
    for (int i = 2; i < 8; i++) begin
      mc[i] = W'($urandom);
      mp[i] = W'($urandom);
    end
    use_dp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dp_mcand  = mc[i];
      dp_mplier = mp[i];
      ref_p = longint'($signed(mc[i])) * longint'($signed(mp[i]));
      @(negedge CLK);
      Begin = 1'b1;
      for (int c = 1; c <= RUN; c++) begin
        @(negedge CLK);
        Begin = 1'b0;
        e = exp_ctl(c, mLSB, Q_neg);
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL dp_ctl v=%0d c=%0d got=%b exp=%b", i, c, obs, e);
        end
      end
      prod = {dp_a[W-1:0], dp_q};
      n_cmp++;
      if (End !== 1'b1 || prod !== ref_p[2*W-1:0]) begin
        n_err++;
        $display("FAIL dp_product v=%0d end=%b got=%h exp=%h",
                 i, End, prod, ref_p[2*W-1:0]);
      end
      @(negedge CLK);
    end
    use_dp = 1'b0;
  endtask

  task automatic test_abort();
    logic [5:0] e;
    int         n_end;
    n_end = 0;
    @(negedge CLK);
    Begin = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      Begin = 1'b0;
      e = exp_ctl(c, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL abort_pre c=%0d got=%b exp=%b", c, obs, e);
      end
    end
    Abort = 1'b1;
    @(negedge CLK);
    Abort = 1'b0;
    n_cmp++;
    if (obs !== 6'b0) begin
      n_err++;
      $display("FAIL abort_c11 got=%b exp=000000", obs);
    end
    for (int c = 12; c <= 40; c++) begin
      @(negedge CLK);
      n_end += int'(End) + int'(Busy);
    end
    n_cmp++;
    if (n_end != 0) begin
      n_err++;
      $display("FAIL abort_quiet got=%0d exp=0", n_end);
    end
    Abort = 1'b1;
    Begin = 1'b1;
    @(negedge CLK);
    Abort = 1'b0;
    Begin = 1'b0;
    n_cmp++;
    if (obs !== 6'b0) begin
      n_err++;
      $display("FAIL abort_idle_block got=%b exp=000000", obs);
    end
    @(negedge CLK);
    Begin = 1'b1;
    for (int c = 1; c <= RUN + 1; c++) begin
      @(negedge CLK);
      Begin = 1'b0;
      e = exp_ctl(c, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL abort_rerun c=%0d got=%b exp=%b", c, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    int         rc;
    @(negedge CLK);
    Begin = 1'b1;
    for (int c = 1; c <= 3 * (RUN + 1); c++) begin
      @(negedge CLK);
      rc = c % (RUN + 1);
      e  = exp_ctl(rc, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, obs, e);
      end
      if (rc >= 2) begin
        n_cmp++;
        if (int'(Iter) != exp_iter(rc)) begin
          n_err++;
          $display("FAIL b2b_iter c=%0d got=%0d exp=%0d",
                   c, Iter, exp_iter(rc));
        end
      end
    end
    Begin = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_datapath();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_sequencer.md
Name: booth_sequencer

Overview:
- Control FSM that sequences the radix-2 Booth multiplier datapath: accumulator shifter, multiplier shifter, Q(-1) flop and adder/subtractor.
- On Begin it clears and loads the datapath, then runs width evaluate/shift iterations.
- Each evaluate cycle decodes the Booth pair {mLSB, Q_neg} into add, subtract or no-op. It then signals End and returns to idle.
- Sits between the top-level Multiplier wrapper and its datapath, and replaces the ad-hoc select logic in the wrapper.

Parameters:
- width, 16: operand width and number of Booth iterations; legal range 2..64.
- CW, $clog2(width): iteration counter width; derived, not overridden.

Ports:
- CLK  input  1  system clock, rising-edge.
- R  input  1  asynchronous, active-low reset.
- Begin  input  1  start request; sampled only in IDLE.
- Abort  input  1  synchronous cancel; forces return to IDLE.
- mLSB  input  1  multiplier register bit 0 (Q0).
- Q_neg  input  1  Q(-1) flop output.
- Init  output  1  datapath clear/load pulse.
- LoadA  output  1  accumulator load from adder/subtractor.
- AddSub  output  1  adder op select: 1 = subtract multiplicand, 0 = add.
- Shift  output  1  arithmetic-shift enable for accumulator, multiplier and Q(-1) flop.
- Busy  output  1  operation in progress.
- End  output  1  one-cycle completion pulse.
- Iter  output  CW  current iteration index.

Behaviour:
- State register and counter are reset asynchronously by R=0, and take effect immediately regardless of CLK.
- While R=0: state IDLE, Iter=0, and Init, LoadA, AddSub, Shift, Busy, End all 0.
- States are IDLE, INIT, EVAL, SHIFT, DONE. State is registered; outputs are decoded from state. LoadA/AddSub are additionally decoded from {mLSB, Q_neg} in EVAL only.
- IDLE: all outputs 0. Begin=1 at a rising edge -> INIT.
- INIT: Init=1 and Busy=1; Iter<=0 -> EVAL.
- EVAL: Busy=1. Pair decode:
  - 10 -> LoadA=1, AddSub=1.
  - 01 -> LoadA=1, AddSub=0.
  - 00 or 11 -> LoadA=0, AddSub=0.
  - Next state is always SHIFT.
- SHIFT: Shift=1 and Busy=1.
  - If Iter==width-1 -> DONE.
  - Otherwise Iter<=Iter+1 -> EVAL.
- DONE: End=1 and Busy=1 for exactly one cycle -> IDLE. Iter holds width-1 until the next INIT.
- Outputs are mutually exclusive: Init, LoadA, Shift and End are never high in the same cycle. AddSub=1 only when LoadA=1.
- Latency: Begin accepted at edge 0.
  - Init is high in cycle 1.
  - EVAL/SHIFT pairs occupy cycles 2..2*width+1.
  - End is high in cycle 2*width+2; for width=16 that is cycle 34.
  - Busy is high in cycles 1..2*width+2.
- Begin is ignored outside IDLE; no queueing.
- Begin held high continuously: a new operation starts on the edge after the cycle spent in IDLE. There is therefore exactly one idle cycle between End and the next Init.
- Abort=1 in any non-IDLE state -> IDLE on the next edge, with no End pulse.
- Abort has priority over all other transitions. Abort in IDLE is a no-op and blocks a simultaneous Begin.
- R deasserted mid-operation: the FSM restarts in IDLE. The datapath contents are don't-care until the next Init.
- Iter never exceeds width-1; no wrap-around occurs.

Test Plan:
- Reset: assert R=0 mid-EVAL. Required: all outputs 0 immediately, before any CLK edge; after release, state IDLE and Iter=0.
- Basic run (width=16), Begin pulsed one cycle, mLSB/Q_neg held 0/0. Required: Init in cycle 1, 16 Shift pulses in cycles 3,5,..,33, LoadA never 1, End only in cycle 34, Busy in cycles 1..34.
- Booth decode: drive pair 10, 01, 11, 00 on successive EVAL cycles. Required:
  - 10 -> LoadA=1, AddSub=1.
  - 01 -> LoadA=1, AddSub=0.
  - 11 and 00 -> LoadA=0.
- End-to-end with datapath: Multiplicand=16'h0007, Multiplier=16'hFFFD (-3). Required: Product=32'hFFFFFFEB (-21) when End=1. Repeat with 16'h8000 x 16'h8000 -> 32'h40000000.
- Abort in cycle 10. Required: Busy=0 in cycle 11, no End pulse; a new Begin then yields a full 34-cycle run.
- Back-to-back: hold Begin=1 continuously. Required: End in cycle 34, IDLE in cycle 35, Init in cycle 36; Begin during Busy causes no restart.
